// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Framed byte-stream loader that packs big-endian 32-bit words into
//            the instruction RAM and releases the CPU on a good checksum.
// Revision : 1.0
// ============================================================================
module prog_loader #(
    parameter int         ADDR_W = 6,
    parameter logic [7:0] MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int c_depth = 2 ** ADDR_W;
    localparam int c_nw    = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_chk, w_chk;
    logic [1:0]        r_idx, w_idx;
    logic [ADDR_W:0]   r_count, w_count;
    logic              w_we, w_cpu_rst, w_done, w_err;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_din;
    logic [ADDR_W:0]   w_wl, w_wl_inc;
    logic              w_accept, w_n_bad;

    assign in_ready = (r_state != S_WRITE);
    assign w_accept = in_valid & in_ready;
    assign w_wl_inc = words_loaded + 1'b1;
    assign w_n_bad  = (in_data == 8'd0) || (32'(in_data) > c_depth);

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_addr      = mem_addr;
        w_din       = mem_din;
        w_cpu_rst   = cpu_reset;
        w_done      = done;
        w_err       = err;
        w_wl        = words_loaded;
        w_chk       = r_chk;
        w_idx       = r_idx;
        w_count     = r_count;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                // MAGIC is a frame start only between frames
                if (w_accept && in_data == MAGIC) begin
                    w_state_nxt = S_COUNT;
                    w_err       = 1'b0;
                    w_done      = 1'b0;
                    w_cpu_rst   = 1'b1;
                    w_wl        = '0;
                    w_chk       = 8'd0;
                    w_idx       = 2'd0;
                end
            end
            S_COUNT: begin
                if (w_accept) begin
                    if (w_n_bad) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_count     = c_nw'(in_data);
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_din = {mem_din[23:0], in_data};
                    w_chk = r_chk ^ in_data;
                    if (r_idx == 2'd3) begin
                        w_idx       = 2'd0;
                        w_we        = 1'b1;
                        w_addr      = words_loaded[ADDR_W-1:0];
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_idx = r_idx + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                w_wl        = w_wl_inc;
                w_state_nxt = (w_wl_inc == r_count) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (w_accept) begin
                    if (in_data == r_chk) begin
                        w_done      = 1'b1;
                        w_cpu_rst   = 1'b0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = S_ERROR;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= 32'd0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            r_chk        <= 8'd0;
            r_idx        <= 2'd0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            mem_we       <= w_we;
            mem_addr     <= w_addr;
            mem_din      <= w_din;
            cpu_reset    <= w_cpu_rst;
            done         <= w_done;
            err          <= w_err;
            words_loaded <= w_wl;
            r_chk        <= w_chk;
            r_idx        <= w_idx;
            r_count      <= w_count;
        end
    end

endmodule
`default_nettype wire
